mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage core.
- Data requests have priority. A starvation counter guarantees that fetch makes forward progress.
- At most one memory transaction is outstanding at a time.
- Uses a req/gnt/rvalid handshake on both sides, so the core can stall on a variable-latency memory.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_DATA_RUN, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address (pc)
- if_gnt_o  out  1  fetch request accepted by memory this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_WIDTH  fetched instruction
- dm_req_i  in  1  data request; held until dm_gnt_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_be_i  in  DATA_WIDTH/8  byte enables
- dm_addr_i  in  ADDR_WIDTH  data address (alu_out)
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_gnt_o  out  1  data request accepted this cycle
- dm_rvalid_o  out  1  load data valid, or write acknowledge
- dm_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  request to memory (registered)
- mem_we_o  out  1  registered
- mem_be_o  out  DATA_WIDTH/8  registered
- mem_addr_o  out  ADDR_WIDTH  registered
- mem_wdata_o  out  DATA_WIDTH  registered
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  response valid (reads and writes)
- mem_rdata_i  in  DATA_WIDTH  response data
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, owner DATA, run counter 0.
- Reset values of outputs: mem_req_o, mem_we_o and err_o are 0; mem_be_o, mem_addr_o and mem_wdata_o are 0. All gnt and rvalid outputs are 0.
- FSM state IDLE: arbitrate when any request is pending. Latch owner and payload (addr, we, be, wdata; fetch uses we=0, be=all ones) and go to REQ. mem_req_o rises the following cycle.
- FSM state REQ: mem_req_o=1 with the payload held stable. When mem_gnt_i=1, assert the owner's *_gnt_o combinationally in that same cycle, clear mem_req_o, and go to RESP.
- FSM state RESP: wait for mem_rvalid_i. When it arrives, pass mem_rdata_i through to the owner's rdata and pulse the owner's rvalid in that cycle. In the same cycle, arbitrate again:
  - if a request is pending, go to REQ, so requests run back-to-back with no idle bubble;
  - otherwise go to IDLE.
- Non-owner outputs: rvalid is 0. rdata is driven with mem_rdata_i, but is don't-care when rvalid is low.
- Arbitration rule: data wins, unless if_req_i=1 and run counter == MAX_DATA_RUN, in which case fetch wins.
- Run counter:
  - increments on each data grant while if_req_i=1;
  - clears on a fetch grant, or whenever if_req_i=0;
  - saturates at MAX_DATA_RUN.
- Minimum latency, from request to rvalid with mem_gnt_i in the first REQ cycle and memory latency 1: req at cycle N, mem_req_o at N+1, gnt at N+1, rvalid at N+2.
- Requester requirements: hold req and payload stable until its gnt. Dropping req before gnt is allowed in IDLE only; once latched, the transaction completes anyway.
- Protocol errors: err_o sets on mem_rvalid_i in IDLE or REQ, or on mem_gnt_i outside REQ. Such rvalid or gnt is ignored and not routed to any requester. err_o clears only on reset.
- Reset mid-transaction: abandon the transaction, return to IDLE, no gnt or rvalid is generated. A late mem_rvalid_i after reset sets err_o.
- Simultaneous if_req_i and dm_req_i in IDLE: data is granted first unless the run counter rule forces fetch.

Decomposition:
- Shared header mem_arb_defs.vh holds:
  - state encodings IDLE/REQ/RESP (2 bits);
  - owner encodings OWN_IF/OWN_DM;
  - default MAX_DATA_RUN.
- One natural sub-module, arb_prio: a fixed-priority arbiter with a starvation run counter. Inputs: clk, rst_n, both requests, and an arbitrate enable. Outputs: the winner, plus a valid flag.
- The FSM, payload latch and response routing stay in mem_arbiter.

Test Plan:
- Single fetch: if_req_i=1, addr=0x10, gnt held high by the memory model, rdata=0x00500093 after 1 cycle. Required: mem_req_o at cycle 1, if_gnt_o at cycle 1, if_rvalid_o at cycle 2 with if_rdata_o=0x00500093, and dm_rvalid_o never asserted.
- Collision: if_req_i and dm_req_i both asserted, read at 0x80, in the same cycle. Required: data transaction first; fetch is issued in the cycle after the data rvalid with no IDLE cycle; two transactions total.
- Starvation: dm_req_i held for 6 requests with if_req_i held high, MAX_DATA_RUN=4. Required: data grants 1-4, then the fetch grant, then data grants 5-6.
- Store: dm_we_i=1, be=4'b0011, wdata=0xDEADBEEF, addr=0x100. Required: mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF while mem_req_o=1; mem_gnt_i is delayed 3 cycles and the payload stays stable throughout; dm_rvalid_o pulses once on the write ack.
- Protocol error and reset: inject mem_rvalid_i in IDLE. Required: err_o=1 and no rvalid routed. Then assert rst_n=0 during RESP. Required: all outputs go to 0 asynchronously and the FSM is in IDLE after reset release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter
// (fetch port vs. data port of the 5-stage core).
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int DEF_MAX_DATA_RUN = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed-priority arbiter: data wins, except that a fetch kept waiting through
// MAX_DATA_RUN consecutive data grants is forced through.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic arb_en_i,
  output logic win_o,
  output logic valid_o
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  logic [CW-1:0] run_cnt_r;
  logic          starve_s;

  assign starve_s = if_req_i && (run_cnt_r == RUN_MAX);
  assign valid_o  = if_req_i || dm_req_i;

  // Winner selection.
  always_comb begin
    win_o = OWN_DM;
    if (if_req_i && (!dm_req_i || starve_s)) begin
      win_o = OWN_IF;
    end else begin
      win_o = OWN_DM;
    end
  end

  // Run counter only advances on an actual arbitration decision; it is
  // meaningless without a waiting fetch, so it clears whenever fetch is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_r <= {CW{1'b0}};
    end else if (!if_req_i) begin
      run_cnt_r <= {CW{1'b0}};
    end else if (arb_en_i && valid_o) begin
      if (win_o == OWN_IF) begin
        run_cnt_r <= {CW{1'b0}};
      end else if (run_cnt_r != RUN_MAX) begin
        run_cnt_r <= run_cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data ports of the
// core; one transaction outstanding, back-to-back issue on the response cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  owner_r;
  logic                  arb_en_s;
  logic                  win_s;
  logic                  win_valid_s;
  logic                  load_s;
  logic                  gnt_s;
  logic                  rsp_s;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [BE_W-1:0]       mem_be_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  err_r;

  arb_prio #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_arb_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req_i (if_req_i),
    .dm_req_i (dm_req_i),
    .arb_en_i (arb_en_s),
    .win_o    (win_s),
    .valid_o  (win_valid_s)
  );

  assign gnt_s    = (state_r == REQ) && mem_gnt_i;
  assign rsp_s    = (state_r == RESP) && mem_rvalid_i;
  // Re-arbitrating on the response cycle is what removes the idle bubble.
  assign arb_en_s = (state_r == IDLE) || rsp_s;
  assign load_s   = arb_en_s && win_valid_s;

  assign if_gnt_o    = gnt_s && (owner_r == OWN_IF);
  assign dm_gnt_o    = gnt_s && (owner_r == OWN_DM);
  assign if_rvalid_o = rsp_s && (owner_r == OWN_IF);
  assign dm_rvalid_o = rsp_s && (owner_r == OWN_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_be_o    = mem_be_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign err_o       = err_r;

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) state_nxt_s = REQ;
        else             state_nxt_s = IDLE;
      end
      REQ: begin
        if (mem_gnt_i) state_nxt_s = RESP;
        else           state_nxt_s = REQ;
      end
      RESP: begin
        if (mem_rvalid_i) state_nxt_s = win_valid_s ? REQ : IDLE;
        else              state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, owner and registered memory-side payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      owner_r     <= OWN_DM;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_W{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        owner_r   <= win_s;
        mem_req_r <= 1'b1;
        if (win_s == OWN_IF) begin
          mem_we_r    <= 1'b0;
          mem_be_r    <= {BE_W{1'b1}};
          mem_addr_r  <= if_addr_i;
          mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
          mem_we_r    <= dm_we_i;
          mem_be_r    <= dm_be_i;
          mem_addr_r  <= dm_addr_i;
          mem_wdata_r <= dm_wdata_i;
        end
      end else if (gnt_s) begin
        mem_req_r <= 1'b0;
      end
    end
  end

  // Sticky flag for memory handshakes arriving in the wrong state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((mem_rvalid_i && (state_r != RESP)) ||
                 (mem_gnt_i && (state_r != REQ))) begin
      err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester/memory models driven per cycle,
// grants and responses checked in order against an expectation queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [BW-1:0] dm_be_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  typedef struct {
    bit            is_dm;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } req_t;

  req_t if_src[$];
  req_t dm_src[$];
  req_t exp_gnt[$];
  req_t exp_rsp[$];

  logic [DW-1:0] mem_a [logic [AW-1:0]];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_rv = 0;
  int  dm_rv_cnt = 0;
  int  if_req_cyc, req_rise_cyc, if_gnt_cyc, if_rv_cyc, dm_rv_cyc;
  int  st_req_cycles = 0;
  int  gnt_delay = 0;
  int  wait_cnt = 0;
  bit  mem_auto = 1'b1;
  bit  rsp_hold = 1'b0;
  bit  gnt_prev = 1'b0;
  bit  req_prev = 1'b0;
  bit  chk_store = 1'b0;
  bit  if_gnt_seen = 1'b0;
  bit  dm_gnt_seen = 1'b0;
  logic [DW-1:0] rsp_data = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic req_t mk(input bit is_dm, input logic we, input logic [BW-1:0] be,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.is_dm = is_dm; r.we = we; r.be = be; r.addr = addr; r.wdata = wdata; r.rdata = 32'h0;
    return r;
  endfunction

  task automatic drive();
    req_t r;
    if (if_gnt_seen) begin if_req_i = 1'b0; if_gnt_seen = 1'b0; end
    if (dm_gnt_seen) begin dm_req_i = 1'b0; dm_gnt_seen = 1'b0; end
    if (!if_req_i && if_src.size() > 0) begin
      r = if_src.pop_front();
      if_req_i = 1'b1; if_addr_i = r.addr; if_req_cyc = cyc;
    end
    if (!dm_req_i && dm_src.size() > 0) begin
      r = dm_src.pop_front();
      dm_req_i = 1'b1; dm_we_i = r.we; dm_be_i = r.be;
      dm_addr_i = r.addr; dm_wdata_i = r.wdata;
    end
  endtask

  task automatic mem_model();
    logic [DW-1:0] w;
    if (rsp_hold) begin
      mem_rvalid_i = 1'b0;
    end else begin
      mem_rvalid_i = gnt_prev;
      mem_rdata_i  = gnt_prev ? rsp_data : 32'h0;
      gnt_prev     = 1'b0;
    end
    mem_gnt_i = mem_req_o && (wait_cnt >= gnt_delay);
    if (mem_gnt_i) begin
      wait_cnt = 0;
      gnt_prev = 1'b1;
      if (mem_we_o) begin
        w = mem_rd(mem_addr_o);
        for (int b = 0; b < BW; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem_a[mem_addr_o] = w;
        rsp_data = 32'h0;
      end else begin
        rsp_data = mem_rd(mem_addr_o);
      end
    end else if (mem_req_o) begin
      wait_cnt++;
    end
  endtask

  task automatic monitor();
    req_t e;
    if (mem_req_o && !req_prev) req_rise_cyc = cyc;
    req_prev = mem_req_o;
    if (chk_store && mem_req_o) begin
      st_req_cycles++;
      check("st_we",    64'(mem_we_o),    64'd1);
      check("st_be",    64'(mem_be_o),    64'h3);
      check("st_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
      check("st_addr",  64'(mem_addr_o),  64'h100);
    end
    if (if_gnt_o || dm_gnt_o) begin
      if (if_gnt_o) begin if_gnt_seen = 1'b1; if_gnt_cyc = cyc; end
      if (dm_gnt_o) dm_gnt_seen = 1'b1;
      if (exp_gnt.size() == 0) begin
        check("gnt_unexp", 64'({if_gnt_o, dm_gnt_o}), 64'd0);
      end else begin
        e = exp_gnt.pop_front();
        check("gnt_port", 64'({if_gnt_o, dm_gnt_o}), e.is_dm ? 64'd1 : 64'd2);
        check("gnt_addr", 64'(mem_addr_o), 64'(e.addr));
        e.rdata = mem_rd(e.addr);
        exp_rsp.push_back(e);
      end
    end
    if (if_rvalid_o || dm_rvalid_o) begin
      n_rv++;
      if (if_rvalid_o) if_rv_cyc = cyc;
      if (dm_rvalid_o) begin dm_rv_cyc = cyc; dm_rv_cnt++; end
      if (exp_rsp.size() == 0) begin
        check("rv_unexp", 64'({if_rvalid_o, dm_rvalid_o}), 64'd0);
      end else begin
        e = exp_rsp.pop_front();
        check("rv_port", 64'({if_rvalid_o, dm_rvalid_o}), e.is_dm ? 64'd1 : 64'd2);
        if (!e.we) check("rv_data", 64'(e.is_dm ? dm_rdata_o : if_rdata_o), 64'(e.rdata));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    if (mem_auto) mem_model();
    #1;
    monitor();
  endtask

  task automatic run_until_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      done = (if_src.size() == 0) && (dm_src.size() == 0) && !if_req_i && !dm_req_i &&
             (exp_gnt.size() == 0) && (exp_rsp.size() == 0);
    end
    check("drain", 64'(done), 64'd1);
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   64'(mem_req_o),   64'd0);
    check({tag, "_we"},    64'(mem_we_o),    64'd0);
    check({tag, "_be"},    64'(mem_be_o),    64'd0);
    check({tag, "_addr"},  64'(mem_addr_o),  64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    check({tag, "_err"},   64'(err_o),       64'd0);
    check({tag, "_hs"},    64'({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}), 64'd0);
    check({tag, "_state"}, 64'(dut.state_r), 64'(IDLE));
  endtask

  initial begin
    int rv0, dmrv0;
    bit got;
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'h0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset state
    #12;
    check_all_zero("rst");
    check("rst_owner", 64'(dut.owner_r), 64'(OWN_DM));
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, minimum latency
    mem_a[32'h10] = 32'h0050_0093;
    if_src.push_back(mk(1'b0, 1'b0, 4'hF, 32'h10, 32'h0));
    exp_gnt.push_back(mk(1'b0, 1'b0, 4'hF, 32'h10, 32'h0));
    dmrv0 = dm_rv_cnt;
    run_until_done(20);
    check("t1_req_lat", 64'(req_rise_cyc - if_req_cyc), 64'd1);
    check("t1_gnt_lat", 64'(if_gnt_cyc - if_req_cyc), 64'd1);
    check("t1_rv_lat",  64'(if_rv_cyc - if_req_cyc), 64'd2);
    check("t1_no_dm_rv", 64'(dm_rv_cnt - dmrv0), 64'd0);

    // Collision: data first, fetch issued right after data rvalid
    rv0 = n_rv;
    dm_src.push_back(mk(1'b1, 1'b0, 4'hF, 32'h80, 32'h0));
    if_src.push_back(mk(1'b0, 1'b0, 4'hF, 32'h14, 32'h0));
    exp_gnt.push_back(mk(1'b1, 1'b0, 4'hF, 32'h80, 32'h0));
    exp_gnt.push_back(mk(1'b0, 1'b0, 4'hF, 32'h14, 32'h0));
    run_until_done(30);
    check("t2_b2b", 64'(req_rise_cyc - dm_rv_cyc), 64'd1);
    check("t2_count", 64'(n_rv - rv0), 64'd2);

    // Starvation: four data grants, forced fetch, then the remaining data
    for (int i = 0; i < 6; i++)
      dm_src.push_back(mk(1'b1, 1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0));
    if_src.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    for (int i = 0; i < 4; i++)
      exp_gnt.push_back(mk(1'b1, 1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0));
    exp_gnt.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    for (int i = 4; i < 6; i++)
      exp_gnt.push_back(mk(1'b1, 1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0));
    run_until_done(80);

    // Store with a slow grant: payload must stay stable
    gnt_delay = 3;
    chk_store = 1'b1;
    dmrv0 = dm_rv_cnt;
    dm_src.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF));
    exp_gnt.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF));
    run_until_done(30);
    chk_store = 1'b0;
    gnt_delay = 0;
    check("t4_req_cycles", 64'(st_req_cycles), 64'd4);
    check("t4_ack", 64'(dm_rv_cnt - dmrv0), 64'd1);
    check("t4_mem", 64'(mem_rd(32'h100)), 64'h5A5ABEEF);
    check("t4_no_err", 64'(err_o), 64'd0);

    // Stray rvalid in IDLE
    mem_auto = 1'b0;
    rv0 = n_rv;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
    cycle();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    cycle();
    check("t5_err_rv", 64'(err_o), 64'd1);
    check("t5_no_route", 64'(n_rv - rv0), 64'd0);

    // Reset while waiting in RESP
    mem_auto = 1'b1;
    rsp_hold = 1'b1;
    dm_src.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0));
    exp_gnt.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = (exp_rsp.size() == 1);
    end
    check("t5_in_resp_gnt", 64'(got), 64'd1);
    cycle();
    cycle();
    check("t5_state_resp", 64'(dut.state_r), 64'(RESP));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_arst");
    exp_rsp.delete();
    rsp_hold = 1'b0;
    gnt_prev = 1'b0;
    mem_auto = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rv0 = n_rv;
    cycle();
    cycle();
    check("t5_idle_after", 64'(dut.state_r), 64'(IDLE));
    check("t5_no_rv", 64'(n_rv - rv0), 64'd0);

    // Late rvalid after reset
    mem_rvalid_i = 1'b1;
    cycle();
    mem_rvalid_i = 1'b0;
    cycle();
    check("t5_late_rv_err", 64'(err_o), 64'd1);
    check("t5_late_no_rv", 64'(n_rv - rv0), 64'd0);

    // Stray grant in IDLE
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_err_clr", 64'(err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_gnt_i = 1'b1;
    cycle();
    mem_gnt_i = 1'b0;
    cycle();
    check("t6_err_gnt", 64'(err_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
